instr_prefetch: RTL and testbench
=================================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  high SHALL enable new fetch requests.
REQ-006 redirect_i  input  1  taken-branch flush, one-cycle pulse from the ID-stage branch compare.
REQ-007 redirect_pc_i  input  32  branch target, sampled when redirect_i is high.
REQ-008 mem_req_o  output  1  instruction-memory request, held until acknowledged.
REQ-009 mem_addr_o  output  32  request address, stable while mem_req_o is high.
REQ-010 mem_ack_i  input  1  one-cycle completion strobe; mem_data_i is valid in the same cycle.
REQ-011 mem_data_i  input  32  returned instruction word.
REQ-012 inst_valid_o  output  1  queue head valid toward IF/ID.
REQ-013 inst_o  output  32  queue-head instruction.
REQ-014 pc_o  output  32  queue-head PC.
REQ-015 inst_ready_i  input  1  IF/ID write enable; inst_valid_o and inst_ready_i high together SHALL pop the head.

Function
REQ-016 FSM states SHALL be IDLE, REQ and DISCARD; mem_req_o SHALL be high only in REQ and DISCARD, and driven from a register.
REQ-017 IDLE→REQ SHALL occur when start_i=1, redirect_i=0 and the post-pop occupancy is below DEPTH; mem_addr_o SHALL equal fetch_pc.
REQ-018 REQ with mem_ack_i=1 SHALL push {fetch_pc, mem_data_i} and set fetch_pc+=4, wrapping 32'hFFFF_FFFC→0.
REQ-019 After an ack, the FSM SHALL stay in REQ (back-to-back, new address next cycle) if the REQ-017 condition still holds, else go to IDLE.
REQ-020 A pushed entry SHALL be visible on inst_valid_o/inst_o/pc_o in the cycle after the ack (latency 1).
REQ-021 inst_valid_o SHALL equal (occupancy != 0); outputs SHALL show the oldest entry; order SHALL be FIFO.
REQ-022 Push and pop in the same cycle SHALL leave occupancy unchanged; the queue SHALL never overflow or underflow.
REQ-023 redirect_i SHALL have priority over every other event: occupancy→0, a concurrent pop ignored, fetch_pc←{redirect_pc_i[31:2],2'b00}.
REQ-024 redirect_i in REQ without ack SHALL move to DISCARD with mem_addr_o held; the stale ack SHALL be dropped, then REQ at the new fetch_pc.
REQ-025 redirect_i coincident with an ack SHALL drop that data and enter REQ at the target next cycle if start_i=1, else IDLE.
REQ-026 redirect_i in DISCARD SHALL only update fetch_pc; in IDLE, a redirect SHALL lead to a request at the target in the cycle after.
REQ-027 start_i=0 SHALL block only new requests; an outstanding request SHALL complete normally.

Reset
REQ-028 rst_i low SHALL immediately force: state IDLE, fetch_pc=RESET_PC, occupancy 0, mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, pc_o=0.
REQ-029 Reset mid-request SHALL abandon it; the memory is reset by the same rst_i, so no stale ack is expected.

Configuration
REQ-030 With PREFETCH_STATS_EN defined, outputs fetch_cnt_o[15:0] (accepted acks) and drop_cnt_o[15:0] (discarded acks plus flushed entries) SHALL exist, saturate at 16'hFFFF and reset to 0.
REQ-031 Without PREFETCH_STATS_EN, these ports and counters SHALL be absent and the remaining behaviour unchanged.

Structure
REQ-032 Package prefetch_pkg SHALL hold the FSM state enum, the entry struct {pc, inst}, and the PC_STEP=4 constant.
REQ-033 Sub-module prefetch_fifo SHALL implement the circular buffer (head/tail pointers, occupancy, push/pop/clear); the FSM and fetch_pc SHALL live in instr_prefetch.

Verification
REQ-034 Reset release, start_i=1, memory ack 1 cycle after each req → addresses 0,4,8,12 requested; pc_o sequence 0,4,8,12 with matching words.
REQ-035 inst_ready_i=0 with DEPTH=4 → exactly 4 entries, mem_req_o low; ready=1 for one cycle → exactly one new request issued.
REQ-036 redirect_i with redirect_pc_i=32'h0000_0103 while req outstanding, ack 3 cycles later → ack data dropped, inst_valid_o=0, next request at 32'h0000_0100.
REQ-037 redirect_i coincident with ack and pop → queue empty next cycle; request at target next cycle; popped entry not reissued.
REQ-038 RESET_PC=32'hFFFF_FFF8 → requests at FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst_i asserted asynchronously mid-REQ → mem_req_o and inst_valid_o low before the next clock edge; with PREFETCH_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instr_prefetch_if.sv
// Instruction-memory request channel plus the IF/ID delivery channel.
interface instr_prefetch_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_ready;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, pc,
        input  mem_ack, mem_data, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, pc,
        output mem_ack, mem_data, inst_ready
    );

endinterface

// File: rtl/prefetch_fifo.sv
// Circular buffer of fetched {pc, inst} entries with show-ahead head output.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  entry_t           push_data_i,
    output entry_t           head_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t           mem_reg [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Guards keep the pointers consistent even if a caller misbehaves.
    assign do_pop  = pop_i && (count_reg != '0);
    assign do_push = push_i && ((count_reg != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (clear_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) tail_reg <= tail_reg + PTR_W'(1);
            if (do_pop)  head_reg <= head_reg + PTR_W'(1);
            if (do_push && !do_pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (!do_push && do_pop)
                count_reg <= count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i)
            mem_reg[tail_reg] <= push_data_i;
    end

    assign head_o  = mem_reg[head_reg];
    assign count_o = count_reg;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: fetch FSM + fetch_pc driving a small FIFO toward IF/ID.
// Define PREFETCH_STATS_EN to add saturating fetch/drop counters.
module instr_prefetch
    import prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
`ifdef PREFETCH_STATS_EN
    output logic [15:0] fetch_cnt_o,
    output logic [15:0] drop_cnt_o,
`endif
    instr_prefetch_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    state_t           state_reg, state_next;
    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [31:0]      mem_addr_reg, mem_addr_next;
    logic             mem_req_reg;
    logic [CNT_W-1:0] count;
    entry_t           head;
    entry_t           push_entry;
    logic             push, pop, inst_valid, issue_ok;
    logic [OCC_W-1:0] occ_next;
    logic [31:0]      target_pc;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && bus.inst_ready && !redirect_i;
    assign push       = (state_reg == ST_REQ) && bus.mem_ack && !redirect_i;
    assign target_pc  = redirect_pc_i & ~32'd3;

    // A new request is only allowed when its data is guaranteed a free slot.
    assign occ_next = redirect_i ? '0
                    : OCC_W'(count) + OCC_W'(push) - OCC_W'(pop);
    assign issue_ok = start_i && (occ_next < OCC_W'(DEPTH));

    assign push_entry.pc   = fetch_pc_reg;
    assign push_entry.inst = bus.mem_data;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .pop_i       (pop),
        .clear_i     (redirect_i),
        .push_data_i (push_entry),
        .head_o      (head),
        .count_o     (count)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
            mem_addr_reg <= '0;
            mem_req_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            mem_addr_reg <= mem_addr_next;
            mem_req_reg  <= (state_next != ST_IDLE);
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        mem_addr_next = mem_addr_reg;
        if (redirect_i)
            fetch_pc_next = target_pc;
        unique case (state_reg)
            ST_IDLE: begin
                if (issue_ok) begin
                    state_next    = ST_REQ;
                    mem_addr_next = fetch_pc_next;
                end
            end
            ST_REQ: begin
                if (redirect_i && !bus.mem_ack) begin
                    // Address stays put until the in-flight ack is swallowed.
                    state_next = ST_DISCARD;
                end else if (bus.mem_ack) begin
                    if (!redirect_i)
                        fetch_pc_next = fetch_pc_reg + PC_STEP;
                    if (issue_ok)
                        mem_addr_next = fetch_pc_next;
                    else
                        state_next = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (bus.mem_ack) begin
                    if (issue_ok) begin
                        state_next    = ST_REQ;
                        mem_addr_next = fetch_pc_next;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.inst_valid = inst_valid;
    assign bus.inst       = inst_valid ? head.inst : '0;
    assign bus.pc         = inst_valid ? head.pc   : '0;

`ifdef PREFETCH_STATS_EN
    logic [15:0] fetch_cnt_reg, drop_cnt_reg;
    logic        drop_ack;
    logic [16:0] drop_sum;

    // Drops are stale acks plus whatever a flush throws away.
    assign drop_ack = bus.mem_ack
                   && ((state_reg == ST_DISCARD) || ((state_reg == ST_REQ) && redirect_i));
    assign drop_sum = {1'b0, drop_cnt_reg} + 17'(drop_ack)
                    + (redirect_i ? 17'(count) : 17'd0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            if (push && (fetch_cnt_reg != 16'hFFFF))
                fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
            drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign fetch_cnt_o = fetch_cnt_reg;
    assign drop_cnt_o  = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch: memory responder, FIFO model, directed scenarios.
module tb_instr_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        start2 = 1'b0;
    logic        redir2 = 1'b0;
    logic [31:0] redir_pc2 = '0;

    instr_prefetch_if bus ();
    instr_prefetch_if bus2 ();

`ifdef PREFETCH_STATS_EN
    logic [15:0] fetch_cnt, drop_cnt, fetch_cnt2, drop_cnt2;
`endif

    instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .start_i       (start_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
`ifdef PREFETCH_STATS_EN
        .fetch_cnt_o   (fetch_cnt),
        .drop_cnt_o    (drop_cnt),
`endif
        .bus           (bus.master)
    );

    instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .start_i       (start2),
        .redirect_i    (redir2),
        .redirect_pc_i (redir_pc2),
`ifdef PREFETCH_STATS_EN
        .fetch_cnt_o   (fetch_cnt2),
        .drop_cnt_o    (drop_cnt2),
`endif
        .bus           (bus2.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commands from the main sequence, applied by the driver at the next falling edge.
    logic        start_cmd = 1'b0;
    logic        ready_cmd = 1'b0;
    int          lat_cmd = 1;
    int          redir_req = 0;
    logic [31:0] redir_pc_cmd = '0;
    logic        redir_on_ack = 1'b0;

    // Model / scoreboard state, owned by the driver process.
    logic [63:0] exp_q [$];
    logic [31:0] pop_log [$];
    logic [31:0] wrap_log [$];
    logic [31:0] exp_pc = '0;
    logic [63:0] e;
    logic        discard_flag = 1'b0;
    int          wait_cnt = 0;
    int          redir_done = 0;
    int          ack_total = 0;
    int          stale_seen = 0;
    int          exp_fetch = 0;
    int          exp_drop = 0;

    initial begin
        bus.mem_ack    = 1'b0;
        bus.mem_data   = '0;
        bus.inst_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.mem_ack    = 1'b0;
                bus.inst_ready = 1'b0;
                start_i        = 1'b0;
                redirect_i     = 1'b0;
                wait_cnt       = 0;
                redir_done     = redir_req;
                exp_q.delete();
                exp_pc         = 32'h0000_0000;
                discard_flag   = 1'b0;
                exp_fetch      = 0;
                exp_drop       = 0;
                continue;
            end
            start_i        = start_cmd;
            bus.inst_ready = ready_cmd;
            redirect_i     = 1'b0;
            // memory responder: ack after lat_cmd waiting cycles
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (bus.mem_req) begin
                if (wait_cnt >= lat_cmd) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = mem_word(bus.mem_addr);
                end else begin
                    wait_cnt++;
                end
            end
            if ((redir_done != redir_req) && (!redir_on_ack || bus.mem_ack)) begin
                redirect_i    = 1'b1;
                redirect_pc_i = redir_pc_cmd;
                redir_done++;
                if (redir_on_ack) bus.inst_ready = 1'b1;
            end
            // model the edge that follows
            check_eq("valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
            if (redirect_i) begin
                exp_drop += exp_q.size();
                exp_q.delete();
            end else if (bus.inst_ready && (exp_q.size() != 0)) begin
                e = exp_q.pop_front();
                check_eq("pop_pc", bus.pc, e[63:32]);
                check_eq("pop_inst", bus.inst, e[31:0]);
                pop_log.push_back(bus.pc);
                $display("pop pc=%h inst=%h", bus.pc, bus.inst);
            end
            if (bus.mem_ack) begin
                ack_total++;
                if (discard_flag || redirect_i) begin
                    exp_drop++;
                    stale_seen++;
                    discard_flag = 1'b0;
                    $display("ack dropped addr=%h", bus.mem_addr);
                end else begin
                    check_eq("req_addr", bus.mem_addr, exp_pc);
                    check_eq("room", 32'(exp_q.size() < DEPTH), 32'd1);
                    exp_q.push_back({exp_pc, bus.mem_data});
                    exp_pc += 32'd4;
                    exp_fetch++;
                end
            end else if (redirect_i && bus.mem_req) begin
                discard_flag = 1'b1;
            end
            if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
        end
    end

    // Second instance: zero-wait memory, always ready, logs request addresses.
    initial begin
        bus2.mem_ack    = 1'b0;
        bus2.mem_data   = '0;
        bus2.inst_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus2.mem_ack = 1'b0;
                start2       = 1'b0;
                continue;
            end
            start2 = 1'b1;
            if (bus2.mem_ack) begin
                bus2.mem_ack = 1'b0;
            end else if (bus2.mem_req) begin
                bus2.mem_ack  = 1'b1;
                bus2.mem_data = mem_word(bus2.mem_addr);
                if (wrap_log.size() < 8) wrap_log.push_back(bus2.mem_addr);
            end
        end
    end

    initial begin
        logic ok;
        int   n;
        logic [31:0] wrap_exp [3];
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_req",   32'(bus.mem_req), 32'd0);
        check_eq("rst_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("rst_inst",  bus.inst, 32'd0);
        check_eq("rst_pc",    bus.pc, 32'd0);
        check_eq("rst_addr",  bus.mem_addr, 32'd0);
        rst_n = 1'b1;

        // sequential fetch with one-cycle memory
        ready_cmd = 1'b1;
        start_cmd = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pop_log.size() >= 4) begin ok = 1'b1; break; end
        end
        check_eq("tmo_seq", 32'(ok), 32'd1);
        start_cmd = 1'b0;
        for (int i = 0; i < 4; i++) check_eq("seq_pc", pop_log[i], 32'(i * 4));
        for (int i = 0; i < 3; i++) check_eq("wrap_addr", wrap_log[i], wrap_exp[i]);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!bus.mem_req && !bus.inst_valid) begin ok = 1'b1; break; end
        end
        check_eq("tmo_drain1", 32'(ok), 32'd1);

        // back-pressure fills the queue, one pop frees one request
        ready_cmd = 1'b0;
        start_cmd = 1'b1;
        repeat (40) tick();
        check_eq("full_valid", 32'(bus.inst_valid), 32'd1);
        check_eq("full_req",   32'(bus.mem_req), 32'd0);
        check_eq("full_cnt",   32'(exp_q.size()), 32'(DEPTH));
        n = ack_total;
        ready_cmd = 1'b1;
        tick();
        ready_cmd = 1'b0;
        repeat (20) tick();
        check_eq("one_req",   32'(ack_total - n), 32'd1);
        check_eq("refull_req", 32'(bus.mem_req), 32'd0);
        ready_cmd = 1'b1;
        start_cmd = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!bus.mem_req && !bus.inst_valid) begin ok = 1'b1; break; end
        end
        check_eq("tmo_drain2", 32'(ok), 32'd1);

        // redirect while a slow request is outstanding
        lat_cmd = 3;
        start_cmd = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.mem_req) begin ok = 1'b1; break; end
        end
        check_eq("tmo_req_c", 32'(ok), 32'd1);
        n = stale_seen;
        redir_pc_cmd = 32'h0000_0103;
        redir_req++;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (stale_seen != n) begin ok = 1'b1; break; end
        end
        check_eq("tmo_stale", 32'(ok), 32'd1);
        check_eq("stale_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("stale_req",   32'(bus.mem_req), 32'd1);
        check_eq("stale_addr",  bus.mem_addr, 32'h0000_0100);
        repeat (12) tick();

        // redirect coincident with an ack and a pop
        ready_cmd = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (exp_q.size() >= 2) begin ok = 1'b1; break; end
        end
        check_eq("tmo_fill_d", 32'(ok), 32'd1);
        redir_on_ack = 1'b1;
        redir_pc_cmd = 32'h0000_0200;
        redir_req++;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (redir_done == redir_req) begin ok = 1'b1; break; end
        end
        check_eq("tmo_redir_d", 32'(ok), 32'd1);
        redir_on_ack = 1'b0;
        check_eq("flush_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("flush_req",   32'(bus.mem_req), 32'd1);
        check_eq("flush_addr",  bus.mem_addr, 32'h0000_0200);
        ready_cmd = 1'b1;
        repeat (20) tick();

`ifdef PREFETCH_STATS_EN
        check_eq("fetch_cnt", 32'(fetch_cnt), 32'(exp_fetch));
        check_eq("drop_cnt",  32'(drop_cnt), 32'(exp_drop));
`endif

        // asynchronous reset in the middle of a request
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.mem_req) begin ok = 1'b1; break; end
        end
        check_eq("tmo_req_e", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_req",   32'(bus.mem_req), 32'd0);
        check_eq("arst_valid", 32'(bus.inst_valid), 32'd0);
        check_eq("arst_addr",  bus.mem_addr, 32'd0);
`ifdef PREFETCH_STATS_EN
        check_eq("arst_fetch", 32'(fetch_cnt), 32'd0);
        check_eq("arst_drop",  32'(drop_cnt), 32'd0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        lat_cmd = 1;
        n = pop_log.size();
        repeat (20) tick();
        check_eq("post_rst_pc", pop_log[n], 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
